fwd_hazard_unit: RTL and testbench

Parametrised successor to the 2-operand EX-stage forwarding logic.
- Generates forwarding selects for NUM_RS source operands.
- Detects load-use hazards.
- Tracks variable-latency producers (multiply/divide, slow loads) in a per-register countdown scoreboard.
- Sits between ID and EX. Drives the operand muxes, the IF/ID stall and the ID/EX bubble insert.

---
 rtl/fwd_hazard_pkg.sv | 22 ++
 rtl/fwd_operand_sel.sv | 34 +++
 rtl/fwd_hazard_unit.sv | 139 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_pkg.sv
// fwd_hazard_pkg
//   Shared types and helpers for the ID/EX forwarding and hazard unit.
//   - fwd_sel_t   : operand mux select encoding (regfile / MEM/WB / EX/MEM)
//   - RA_W_DEF    : default register address width
//   - lat_clamp() : limits a producer's declared extra latency to the maximum
//                   the scoreboard counters can represent
package fwd_hazard_pkg;

  localparam int RA_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  function automatic int unsigned lat_clamp(input int unsigned lat,
                                            input int unsigned max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel
//   Forward select for a single EX-stage source operand. EX/MEM has
//   priority over MEM/WB because it holds the younger result; x0 is never
//   forwarded since it always reads as zero.
// Ports:
//   rs             in  source register of the operand in EX
//   exmem_rd       in  EX/MEM destination
//   exmem_regwrite in  EX/MEM writes a register
//   memwb_rd       in  MEM/WB destination
//   memwb_regwrite in  MEM/WB writes a register
//   sel            out FWD_EXMEM / FWD_MEMWB / FWD_RF
module fwd_operand_sel
  import fwd_hazard_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_regwrite,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_regwrite,
  output fwd_sel_t        sel
);

  always_comb begin
    sel = FWD_RF;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and hazard control between ID and EX.
//   - Per-operand forward selects for NUM_RS EX-stage sources.
//   - Load-use detection against the instruction in EX.
//   - Per-register countdown scoreboard for variable-latency producers;
//     an ID instruction reading a register with a nonzero count stalls.
//   Optional build macro FWD_HAZARD_PERF_EN adds a saturating stall-cycle
//   counter on stall_count; without it the port reads 0 and no flops exist.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   id_rs, id_valid               sources / validity of the ID instruction
//   idex_rs, idex_rd, idex_memread  EX instruction sources, dest, is-load
//   exmem_rd, exmem_regwrite      EX/MEM writeback info
//   memwb_rd, memwb_regwrite      MEM/WB writeback info
//   issue_valid/rd/regwrite/lat   instruction moving ID->EX and its latency
//   flush                         branch redirect, kills the ID instruction
//   forward_sel                   2 bits per operand (00 RF, 10 EX/MEM, 01 MEM/WB)
//   stall, bubble                 hold IF/ID, insert NOP into ID/EX
//   stall_count                   saturating stall-cycle count (perf build)
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter  int RA_W    = RA_W_DEF,
  parameter  int NUM_RS  = 2,
  parameter  int MAX_LAT = 7,
  localparam int CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RS*RA_W-1:0] id_rs,
  input  logic                   id_valid,
  input  logic [NUM_RS*RA_W-1:0] idex_rs,
  input  logic [RA_W-1:0]        idex_rd,
  input  logic                   idex_memread,
  input  logic [RA_W-1:0]        exmem_rd,
  input  logic                   exmem_regwrite,
  input  logic [RA_W-1:0]        memwb_rd,
  input  logic                   memwb_regwrite,
  input  logic                   issue_valid,
  input  logic [RA_W-1:0]        issue_rd,
  input  logic                   issue_regwrite,
  input  logic [CNT_W-1:0]       issue_lat,
  input  logic                   flush,
  output logic [2*NUM_RS-1:0]    forward_sel,
  output logic                   stall,
  output logic                   bubble,
  output logic [15:0]            stall_count
);

  localparam int NREG = 2 ** RA_W;

  // ---------------- EX-stage operand forwarding ----------------
  for (genvar g = 0; g < NUM_RS; g++) begin : g_fwd
    fwd_sel_t sel;

    fwd_operand_sel #(
      .RA_W(RA_W)
    ) u_sel (
      .rs             (idex_rs[g*RA_W +: RA_W]),
      .exmem_rd       (exmem_rd),
      .exmem_regwrite (exmem_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_regwrite (memwb_regwrite),
      .sel            (sel)
    );

    assign forward_sel[2*g +: 2] = sel;
  end

  // ---------------- Latency scoreboard ----------------
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] lat_c;

  assign lat_c = CNT_W'(lat_clamp(32'(issue_lat), MAX_LAT));

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CNT_W'(1)) : '0;
    end
    // The newest producer wins, even over a count expiring this cycle.
    if (issue_valid && issue_regwrite && (issue_rd != '0) && (issue_lat != '0)) begin
      cnt_d[issue_rd] = lat_c;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------- ID-stage hazard detection ----------------
  logic load_use;
  logic sb_busy;

  always_comb begin
    logic [RA_W-1:0] rs;
    rs       = '0;
    load_use = 1'b0;
    sb_busy  = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs = id_rs[i*RA_W +: RA_W];
      if (rs != '0) begin
        if (idex_memread && (idex_rd != '0) && (idex_rd == rs)) load_use = 1'b1;
        if (cnt_q[rs] != '0) sb_busy = 1'b1;
      end
    end
  end

  assign stall  = id_valid && !flush && (load_use || sb_busy);
  assign bubble = stall;

  // ---------------- Optional stall-cycle counter ----------------
`ifdef FWD_HAZARD_PERF_EN
  logic [15:0] stall_count_q;
  logic [15:0] stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  import fwd_hazard_pkg::*;

  localparam int RA_W    = 5;
  localparam int NUM_RS  = 2;
  localparam int MAX_LAT = 7;
  localparam int CNT_W   = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_RS*RA_W-1:0] id_rs;
  logic                   id_valid;
  logic [NUM_RS*RA_W-1:0] idex_rs;
  logic [RA_W-1:0]        idex_rd;
  logic                   idex_memread;
  logic [RA_W-1:0]        exmem_rd;
  logic                   exmem_regwrite;
  logic [RA_W-1:0]        memwb_rd;
  logic                   memwb_regwrite;
  logic                   issue_valid;
  logic [RA_W-1:0]        issue_rd;
  logic                   issue_regwrite;
  logic [CNT_W-1:0]       issue_lat;
  logic                   flush;
  logic [2*NUM_RS-1:0]    forward_sel;
  logic                   stall;
  logic                   bubble;
  logic [15:0]            stall_count;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .RA_W    (RA_W),
    .NUM_RS  (NUM_RS),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_valid       (id_valid),
    .idex_rs        (idex_rs),
    .idex_rd        (idex_rd),
    .idex_memread   (idex_memread),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_regwrite (issue_regwrite),
    .issue_lat      (issue_lat),
    .flush          (flush),
    .forward_sel    (forward_sel),
    .stall          (stall),
    .bubble         (bubble),
    .stall_count    (stall_count)
  );

  typedef struct {
    string               name;
    logic                stall;
    logic [2*NUM_RS-1:0] fs;
    logic [15:0]         sc;
  } exp_t;

  typedef struct {
    string               name;
    logic [9:0]          id_rs;
    logic                id_valid;
    logic [9:0]          idex_rs;
    logic [4:0]          idex_rd;
    logic                memread;
    logic [4:0]          exmem_rd;
    logic                exmem_rw;
    logic [4:0]          memwb_rd;
    logic                memwb_rw;
    logic                flush;
    logic                stall;
    logic [3:0]          fs;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[13];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_sc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    id_rs          = '0;
    id_valid       = 1'b0;
    idex_rs        = '0;
    idex_rd        = '0;
    idex_memread   = 1'b0;
    exmem_rd       = '0;
    exmem_regwrite = 1'b0;
    memwb_rd       = '0;
    memwb_regwrite = 1'b0;
    issue_valid    = 1'b0;
    issue_rd       = '0;
    issue_regwrite = 1'b0;
    issue_lat      = '0;
    flush          = 1'b0;
  endtask

  // Inputs are already applied (just after a rising edge). Push the
  // expectation, compare at the falling edge, then advance past the next
  // rising edge and update the stall-counter model.
  task automatic step(input string name, input logic es, input logic [3:0] efs);
    exp_t e;
    e.name  = name;
    e.stall = es;
    e.fs    = efs;
    e.sc    = 16'(model_sc);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.name, "/stall"},  32'(stall),       32'(e.stall));
    check({e.name, "/bubble"}, 32'(bubble),      32'(e.stall));
    check({e.name, "/fwd"},    32'(forward_sel), 32'(e.fs));
    check({e.name, "/scnt"},   32'(stall_count), 32'(e.sc));
    @(posedge clk);
    #1;
`ifdef FWD_HAZARD_PERF_EN
    if (reset) model_sc = 0;
    else if (es && model_sc < 65535) model_sc++;
`endif
  endtask

  initial begin
    vecs[0]  = '{"fwd_pri_exmem",  {5'd0,5'd0}, 1'b0, {5'd0,5'd5}, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0010};
    vecs[1]  = '{"fwd_memwb",      {5'd0,5'd0}, 1'b0, {5'd0,5'd5}, 5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[2]  = '{"fwd_x0",         {5'd0,5'd0}, 1'b0, {5'd0,5'd0}, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{"fwd_op1_memwb",  {5'd0,5'd0}, 1'b0, {5'd3,5'd9}, 5'd0, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 4'b0100};
    vecs[4]  = '{"fwd_both_exmem", {5'd0,5'd0}, 1'b0, {5'd6,5'd6}, 5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'b1010};
    vecs[5]  = '{"fwd_memwb_norw", {5'd0,5'd0}, 1'b0, {5'd8,5'd0}, 5'd0, 1'b0, 5'd1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{"ldu_op0",        {5'd0,5'd7}, 1'b1, {5'd0,5'd0}, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[7]  = '{"ldu_flush",      {5'd0,5'd7}, 1'b1, {5'd0,5'd0}, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[8]  = '{"ldu_noid",       {5'd0,5'd7}, 1'b0, {5'd0,5'd0}, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[9]  = '{"ldu_op1",        {5'd7,5'd2}, 1'b1, {5'd0,5'd0}, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[10] = '{"ldu_x0",         {5'd0,5'd0}, 1'b1, {5'd0,5'd0}, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{"ldu_noload",     {5'd0,5'd7}, 1'b1, {5'd0,5'd0}, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[12] = '{"ldu_and_fwd",    {5'd0,5'd7}, 1'b1, {5'd0,5'd7}, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0010};

    quiet();
    reset = 1'b1;
    @(posedge clk); #1;
    step("reset_state", 1'b0, 4'b0000);
    reset = 1'b0;
    step("after_reset", 1'b0, 4'b0000);

    // Combinational forwarding / load-use table
    for (int v = 0; v < 13; v++) begin
      id_rs          = vecs[v].id_rs;
      id_valid       = vecs[v].id_valid;
      idex_rs        = vecs[v].idex_rs;
      idex_rd        = vecs[v].idex_rd;
      idex_memread   = vecs[v].memread;
      exmem_rd       = vecs[v].exmem_rd;
      exmem_regwrite = vecs[v].exmem_rw;
      memwb_rd       = vecs[v].memwb_rd;
      memwb_regwrite = vecs[v].memwb_rw;
      flush          = vecs[v].flush;
      step(vecs[v].name, vecs[v].stall, vecs[v].fs);
    end
    quiet();

    // x0 producer never occupies the scoreboard
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 5'd0; issue_lat = 3'd3;
    step("x0_issue", 1'b0, 4'b0000);
    quiet();
    id_valid = 1'b1; id_rs = {5'd0, 5'd0};
    step("x0_no_stall", 1'b0, 4'b0000);
    quiet();

    // Producer rd=9 lat=3: dependent stalls exactly 3 cycles
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 5'd9; issue_lat = 3'd3;
    step("lat3_issue", 1'b0, 4'b0000);
    quiet();
    id_valid = 1'b1; id_rs = {5'd9, 5'd0};
    step("lat3_c1", 1'b1, 4'b0000);
    step("lat3_c2", 1'b1, 4'b0000);
    step("lat3_c3", 1'b1, 4'b0000);
    step("lat3_done", 1'b0, 4'b0000);
    flush = 1'b1;
    step("lat3_flush_idle", 1'b0, 4'b0000);
    quiet();

    // Reissue during countdown: lat 2 then lat 5 one cycle later
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 5'd9; issue_lat = 3'd2;
    step("reiss_first", 1'b0, 4'b0000);
    issue_lat = 3'd5; id_valid = 1'b1; id_rs = {5'd9, 5'd0};
    step("reiss_second", 1'b1, 4'b0000);
    issue_valid = 1'b0; issue_regwrite = 1'b0; issue_lat = '0;
    for (int k = 0; k < 5; k++) step("reiss_hold", 1'b1, 4'b0000);
    step("reiss_done", 1'b0, 4'b0000);
    quiet();

    // Reissue on the cycle the old count expires: newest producer wins
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 5'd12; issue_lat = 3'd1;
    step("exp_first", 1'b0, 4'b0000);
    issue_lat = 3'd2; id_valid = 1'b1; id_rs = {5'd0, 5'd12};
    step("exp_second", 1'b1, 4'b0000);
    issue_valid = 1'b0; issue_regwrite = 1'b0; issue_lat = '0;
    step("exp_hold1", 1'b1, 4'b0000);
    step("exp_hold2", 1'b1, 4'b0000);
    step("exp_done", 1'b0, 4'b0000);
    quiet();

    // Flush masks a scoreboard stall but does not clear the count
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 5'd9; issue_lat = 3'd7;
    step("rst_issue", 1'b0, 4'b0000);
    quiet();
    id_valid = 1'b1; id_rs = {5'd9, 5'd0};
    step("rst_busy", 1'b1, 4'b0000);
    flush = 1'b1;
    step("rst_flushed", 1'b0, 4'b0000);
    flush = 1'b0;
    step("rst_busy2", 1'b1, 4'b0000);
    reset = 1'b1;
    step("rst_cycle", 1'b1, 4'b0000);
    reset = 1'b0;
    step("rst_cleared", 1'b0, 4'b0000);
    quiet();

    // Stall counter: 4 stalled cycles after reset, then saturation
    reset = 1'b1;
    step("perf_reset", 1'b0, 4'b0000);
    reset = 1'b0;
    id_valid = 1'b1; id_rs = {5'd0, 5'd7}; idex_rd = 5'd7; idex_memread = 1'b1;
    for (int k = 0; k < 4; k++) step("perf_stall", 1'b1, 4'b0000);
    quiet();
    step("perf_four", 1'b0, 4'b0000);
    id_valid = 1'b1; id_rs = {5'd0, 5'd7}; idex_rd = 5'd7; idex_memread = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
`ifdef FWD_HAZARD_PERF_EN
    model_sc = (model_sc + 70000 > 65535) ? 65535 : model_sc + 70000;
`endif
    quiet();
    step("perf_sat", 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
